// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - ID/EX pipeline register with bubble/freeze control and bubble statistics
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   id_*               decoded instruction fields from the ID stage
//   stall, flush, hold hazard stall, EX branch flush, global freeze
//   ex_*, rd_ID_EX,    registered EX-stage copies; rd_ID_EX / mem_read_ID_EX
//   mem_read_ID_EX     also feed the load-use hazard detector
//   stall_bubbles,     saturating counts of stall- and flush-induced bubbles
//   flush_bubbles

module id_ex_pipeline_reg #(
  parameter int XLEN    = 64,
  parameter int REG_W   = 6,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [REG_W-1:0]   id_rs1,
  input  logic [REG_W-1:0]   id_rs2,
  input  logic [REG_W-1:0]   id_rd,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alu_src,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_branch,
  input  logic               stall,
  input  logic               flush,
  input  logic               hold,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [REG_W-1:0]   ex_rs1,
  output logic [REG_W-1:0]   ex_rs2,
  output logic [REG_W-1:0]   rd_ID_EX,
  output logic               mem_read_ID_EX,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_branch,
  output logic [CNT_W-1:0]   stall_bubbles,
  output logic [CNT_W-1:0]   flush_bubbles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic load_bubble;
  logic capture;
  logic rd_is_x0;

  // Flush wins over everything; hold freezes unless flushed; stall and an
  // empty decode slot both inject a bubble.
  assign load_bubble = flush | (~hold & (stall | ~id_valid));
  assign capture     = ~flush & ~hold & ~stall & id_valid;
  assign rd_is_x0    = (id_rd == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      rd_ID_EX       <= '0;
      mem_read_ID_EX <= 1'b0;
      ex_alu_op      <= '0;
      ex_alu_src     <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_branch      <= 1'b0;
      stall_bubbles  <= '0;
      flush_bubbles  <= '0;
    end else begin
      // Statistics: a simultaneous flush and stall is a single flush event.
      if (flush) begin
        if (flush_bubbles != CNT_MAX) flush_bubbles <= flush_bubbles + CNT_ONE;
      end else if (!hold && stall) begin
        if (stall_bubbles != CNT_MAX) stall_bubbles <= stall_bubbles + CNT_ONE;
      end

      if (load_bubble) begin
        ex_valid       <= 1'b0;
        ex_pc          <= '0;
        ex_rs1_data    <= '0;
        ex_rs2_data    <= '0;
        ex_imm         <= '0;
        ex_rs1         <= '0;
        ex_rs2         <= '0;
        rd_ID_EX       <= '0;
        mem_read_ID_EX <= 1'b0;
        ex_alu_op      <= '0;
        ex_alu_src     <= 1'b0;
        ex_mem_write   <= 1'b0;
        ex_reg_write   <= 1'b0;
        ex_mem_to_reg  <= 1'b0;
        ex_branch      <= 1'b0;
      end else if (capture) begin
        ex_valid       <= 1'b1;
        ex_pc          <= id_pc;
        ex_rs1_data    <= id_rs1_data;
        ex_rs2_data    <= id_rs2_data;
        ex_imm         <= id_imm;
        ex_rs1         <= id_rs1;
        ex_rs2         <= id_rs2;
        // A write to x0 is architecturally void; dropping reg_write and
        // mem_read here keeps the hazard detector from stalling on x0.
        rd_ID_EX       <= id_rd;
        mem_read_ID_EX <= id_mem_read & ~rd_is_x0;
        ex_reg_write   <= id_reg_write & ~rd_is_x0;
        ex_alu_op      <= id_alu_op;
        ex_alu_src     <= id_alu_src;
        ex_mem_write   <= id_mem_write;
        ex_mem_to_reg  <= id_mem_to_reg;
        ex_branch      <= id_branch;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb/tb_id_ex_pipeline_reg.sv - self-checking bench for id_ex_pipeline_reg
module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [5:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic stall, flush, hold;

  // Instance a: default 16-bit counters. Instance b: 4-bit counters.
  logic        ex_valid_a, mem_read_ID_EX_a, ex_alu_src_a, ex_mem_write_a, ex_reg_write_a, ex_mem_to_reg_a, ex_branch_a;
  logic [63:0] ex_pc_a, ex_rs1_data_a, ex_rs2_data_a, ex_imm_a;
  logic [5:0]  ex_rs1_a, ex_rs2_a, rd_ID_EX_a;
  logic [3:0]  ex_alu_op_a;
  logic [15:0] stall_bubbles_a, flush_bubbles_a;
  logic        ex_valid_b, mem_read_ID_EX_b, ex_alu_src_b, ex_mem_write_b, ex_reg_write_b, ex_mem_to_reg_b, ex_branch_b;
  logic [63:0] ex_pc_b, ex_rs1_data_b, ex_rs2_data_b, ex_imm_b;
  logic [5:0]  ex_rs1_b, ex_rs2_b, rd_ID_EX_b;
  logic [3:0]  ex_alu_op_b;
  logic [3:0]  stall_bubbles_b, flush_bubbles_b;

  id_ex_pipeline_reg dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .stall(stall), .flush(flush), .hold(hold),
    .ex_valid(ex_valid_a), .ex_pc(ex_pc_a), .ex_rs1_data(ex_rs1_data_a), .ex_rs2_data(ex_rs2_data_a),
    .ex_imm(ex_imm_a), .ex_rs1(ex_rs1_a), .ex_rs2(ex_rs2_a), .rd_ID_EX(rd_ID_EX_a),
    .mem_read_ID_EX(mem_read_ID_EX_a), .ex_alu_op(ex_alu_op_a), .ex_alu_src(ex_alu_src_a),
    .ex_mem_write(ex_mem_write_a), .ex_reg_write(ex_reg_write_a), .ex_mem_to_reg(ex_mem_to_reg_a),
    .ex_branch(ex_branch_a), .stall_bubbles(stall_bubbles_a), .flush_bubbles(flush_bubbles_a)
  );

  id_ex_pipeline_reg #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .stall(stall), .flush(flush), .hold(hold),
    .ex_valid(ex_valid_b), .ex_pc(ex_pc_b), .ex_rs1_data(ex_rs1_data_b), .ex_rs2_data(ex_rs2_data_b),
    .ex_imm(ex_imm_b), .ex_rs1(ex_rs1_b), .ex_rs2(ex_rs2_b), .rd_ID_EX(rd_ID_EX_b),
    .mem_read_ID_EX(mem_read_ID_EX_b), .ex_alu_op(ex_alu_op_b), .ex_alu_src(ex_alu_src_b),
    .ex_mem_write(ex_mem_write_b), .ex_reg_write(ex_reg_write_b), .ex_mem_to_reg(ex_mem_to_reg_b),
    .ex_branch(ex_branch_b), .stall_bubbles(stall_bubbles_b), .flush_bubbles(flush_bubbles_b)
  );

  ex_t act_a, act_b;
  assign act_a = {ex_valid_a, ex_pc_a, ex_rs1_data_a, ex_rs2_data_a, ex_imm_a, ex_rs1_a, ex_rs2_a,
                  rd_ID_EX_a, ex_alu_op_a, ex_alu_src_a, mem_read_ID_EX_a, ex_mem_write_a,
                  ex_reg_write_a, ex_mem_to_reg_a, ex_branch_a};
  assign act_b = {ex_valid_b, ex_pc_b, ex_rs1_data_b, ex_rs2_data_b, ex_imm_b, ex_rs1_b, ex_rs2_b,
                  rd_ID_EX_b, ex_alu_op_b, ex_alu_src_b, mem_read_ID_EX_b, ex_mem_write_b,
                  ex_reg_write_b, ex_mem_to_reg_b, ex_branch_b};

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit check_on = 1'b0;

  // Reference model: EX contents as an instruction record, event counts as
  // unbounded integers clipped to each instance's counter range.
  ex_t exp_ex = '0;
  int  n_stall = 0;
  int  n_flush = 0;

  function automatic ex_t captured();
    ex_t r;
    r = '{valid: 1'b1, pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
          rs1: id_rs1, rs2: id_rs2, rd: id_rd, alu_op: id_alu_op, alu_src: id_alu_src,
          mem_read: id_mem_read, mem_write: id_mem_write, reg_write: id_reg_write,
          mem_to_reg: id_mem_to_reg, branch: id_branch};
    if (id_rd == 0) begin
      r.mem_read  = 1'b0;
      r.reg_write = 1'b0;
    end
    return r;
  endfunction

  function automatic int clip(int n, int max);
    return (n > max) ? max : n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_ex  <= '0;
      n_stall <= 0;
      n_flush <= 0;
    end else if (flush) begin
      exp_ex  <= '0;
      n_flush <= n_flush + 1;
    end else if (hold) begin
      exp_ex  <= exp_ex;
    end else if (stall) begin
      exp_ex  <= '0;
      n_stall <= n_stall + 1;
    end else if (!id_valid) begin
      exp_ex  <= '0;
    end else begin
      exp_ex  <= captured();
    end
  end

  always @(posedge clk) begin
    if (rst && id_valid && !flush && !hold && !stall)
      assert (!(id_mem_read && id_mem_write)) else $error("illegal mem_read+mem_write captured");
  end

  always @(negedge clk) begin
    if (rst && check_on) begin
      total += 4;
      if (act_a !== exp_ex) begin
        bad++;
        $display("FAIL ex_fields_a t=%0t got=%h want=%h", $time, act_a, exp_ex);
      end
      if (act_b !== exp_ex) begin
        bad++;
        $display("FAIL ex_fields_b t=%0t got=%h want=%h", $time, act_b, exp_ex);
      end
      if (stall_bubbles_a !== 16'(clip(n_stall, 65535)) || flush_bubbles_a !== 16'(clip(n_flush, 65535))) begin
        bad++;
        $display("FAIL counters_a t=%0t got=%0d/%0d want=%0d/%0d", $time, stall_bubbles_a, flush_bubbles_a,
                 clip(n_stall, 65535), clip(n_flush, 65535));
      end
      if (stall_bubbles_b !== 4'(clip(n_stall, 15)) || flush_bubbles_b !== 4'(clip(n_flush, 15))) begin
        bad++;
        $display("FAIL counters_b t=%0t got=%0d/%0d want=%0d/%0d", $time, stall_bubbles_b, flush_bubbles_b,
                 clip(n_stall, 15), clip(n_flush, 15));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic clear_in();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_alu_op = 0; id_alu_src = 0; id_mem_read = 0; id_mem_write = 0;
    id_reg_write = 0; id_mem_to_reg = 0; id_branch = 0; stall = 0; flush = 0; hold = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    rst = 0;
    repeat (2) step();
    chk("reset_valid", 64'(ex_valid_a), 64'd0);
    chk("reset_stall_cnt", 64'(stall_bubbles_a), 64'd0);
    chk("reset_flush_cnt", 64'(flush_bubbles_b), 64'd0);
    rst = 1;
    check_on = 1;

    // pass-through
    id_valid = 1; id_pc = 64'h100; id_rd = 5; id_reg_write = 1; id_imm = 64'hFFFF_FFFF_FFFF_FFF0;
    id_rs1 = 3; id_rs1_data = 64'hDEAD_BEEF;
    step();
    chk("pt_pc", ex_pc_a, 64'h100);
    chk("pt_rd", 64'(rd_ID_EX_a), 64'd5);
    chk("pt_reg_write", 64'(ex_reg_write_a), 64'd1);
    chk("pt_imm", ex_imm_a, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("pt_valid", 64'(ex_valid_a), 64'd1);

    // load-use
    clear_in();
    id_valid = 1; id_pc = 64'h104; id_rd = 7; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    step();
    chk("lu_mem_read", 64'(mem_read_ID_EX_a), 64'd1);
    chk("lu_rd", 64'(rd_ID_EX_a), 64'd7);
    clear_in();
    id_valid = 1; id_pc = 64'h108; id_rd = 8; id_rs1 = 7; id_reg_write = 1; stall = 1;
    step();
    chk("lu_bubble_valid", 64'(ex_valid_a), 64'd0);
    chk("lu_bubble_rd", 64'(rd_ID_EX_a), 64'd0);
    chk("lu_bubble_mem_read", 64'(mem_read_ID_EX_a), 64'd0);
    chk("lu_stall_cnt", 64'(stall_bubbles_a), 64'd1);
    stall = 0;
    step();
    chk("lu_resume_pc", ex_pc_a, 64'h108);

    // flush beats hold and stall
    flush = 1; hold = 1; stall = 1;
    step();
    chk("fl_valid", 64'(ex_valid_a), 64'd0);
    chk("fl_flush_cnt", 64'(flush_bubbles_a), 64'd1);
    chk("fl_stall_cnt", 64'(stall_bubbles_a), 64'd1);
    clear_in();
    id_valid = 1; id_pc = 64'h200; id_rd = 9;
    step();
    id_pc = 64'h204; hold = 1; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pc", ex_pc_a, 64'h200);
      chk("hold_stall_cnt", 64'(stall_bubbles_a), 64'd1);
    end

    // x0 destination
    clear_in();
    id_valid = 1; id_pc = 64'h300; id_rd = 0; id_reg_write = 1; id_mem_read = 1;
    step();
    chk("x0_reg_write", 64'(ex_reg_write_a), 64'd0);
    chk("x0_mem_read", 64'(mem_read_ID_EX_a), 64'd0);
    chk("x0_rd", 64'(rd_ID_EX_a), 64'd0);
    chk("x0_valid", 64'(ex_valid_a), 64'd1);

    // saturation on the 4-bit instance
    stall = 1;
    repeat (20) step();
    chk("sat_small", 64'(stall_bubbles_b), 64'd15);
    chk("sat_wide", 64'(stall_bubbles_a), 64'd21);

    // asynchronous reset mid-stream, with hold/flush pending
    clear_in();
    id_valid = 1; id_pc = 64'h400; id_rd = 4;
    step();
    chk("pre_reset_valid", 64'(ex_valid_a), 64'd1);
    hold = 1; flush = 1;
    #2 rst = 0;
    #1;
    chk("async_valid", 64'(ex_valid_a), 64'd0);
    chk("async_pc", ex_pc_a, 64'd0);
    chk("async_stall_cnt", 64'(stall_bubbles_b), 64'd0);
    chk("async_flush_cnt", 64'(flush_bubbles_a), 64'd0);
    step();
    rst = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      id_valid      = ($urandom_range(0, 9) < 8);
      id_pc         = {$urandom, $urandom};
      id_rs1_data   = {$urandom, $urandom};
      id_rs2_data   = {$urandom, $urandom};
      id_imm        = {$urandom, $urandom};
      id_rs1        = 6'($urandom);
      id_rs2        = 6'($urandom);
      id_rd         = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      id_alu_op     = 4'($urandom);
      id_alu_src    = 1'($urandom);
      id_mem_read   = 1'($urandom);
      id_mem_write  = id_mem_read ? 1'b0 : 1'($urandom);
      id_reg_write  = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      id_branch     = 1'($urandom);
      stall         = ($urandom_range(0, 99) < 15);
      flush         = ($urandom_range(0, 99) < 10);
      hold          = ($urandom_range(0, 99) < 15);
      step();
    end

    check_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register between decode and execute.
- Captures decoded operands and control each cycle.
- Drives rd_ID_EX / mem_read_ID_EX back to the load-use hazard detector.
- Converts the hazard detector's stall, EX-stage branch flush and a global hold into bubble insertion or freeze, and keeps saturating bubble statistics.

Parameters:
- XLEN, 64, data/PC/immediate width
- REG_W, 6, register-index width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  REG_W  register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  ALUOP_W  ALU operation
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each  control bits
- stall  in  1  load-use stall from hazard detector
- flush  in  1  taken branch resolved in EX
- hold  in  1  global freeze (memory wait)
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2  out  REG_W  registered source indices (for forwarding)
- rd_ID_EX  out  REG_W  registered destination index
- mem_read_ID_EX  out  1  registered mem_read
- ex_alu_op  out  ALUOP_W; ex_alu_src, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each
- stall_bubbles, flush_bubbles  out  CNT_W  saturating event counters

Behaviour:
- Reset (rst=0, asynchronous, immediate): all outputs 0, including both counters. Release is synchronous to the next clk edge.
- Each rising edge, exactly one action applies, in priority order:
  1. flush=1 -> load bubble; flush_bubbles += 1.
  2. hold=1 -> keep all registers unchanged (stall is ignored).
  3. stall=1 -> load bubble; stall_bubbles += 1.
  4. id_valid=0 -> load bubble; no counter changes.
  5. Otherwise -> capture all id_* fields; ex_valid=1.
- Bubble definition: every output register except the counters loads 0, including data, PC, indices and all control bits.
- Latency: an id_* value appears on the ex_* outputs one cycle after the capturing edge. There is no combinational path from inputs to outputs.
- x0 rule: on capture with id_rd==0, ex_reg_write and mem_read_ID_EX are forced to 0 and rd_ID_EX=0. This prevents false load-use stalls on x0.
- id_mem_read=1 together with id_mem_write=1 is illegal. Capture it as presented; verification flags it with an assertion.
- Counters saturate at 2^CNT_W-1 and never wrap. flush and stall asserted together count only flush.
- Reset mid-operation overrides any pending hold, stall or flush. The first edge after release performs normal priority evaluation.

Test Plan:
- Reset: rst=0 mid-stream with ex_valid=1 -> all outputs 0 immediately, without a clock edge; counters 0.
- Pass-through: id_pc=0x100, id_rd=5, id_reg_write=1, id_imm=0xFFFF_FFFF_FFFF_FFF0 -> next cycle ex_pc=0x100, rd_ID_EX=5, ex_reg_write=1, ex_imm matches, ex_valid=1.
- Load-use: capture a load to rd=7 (mem_read_ID_EX=1), then stall=1 for one cycle -> following cycle is a bubble (ex_valid=0, rd_ID_EX=0, mem_read_ID_EX=0), stall_bubbles=1; the held ID instruction is captured after stall drops.
- Flush vs hold/stall: flush=1, hold=1, stall=1 together -> bubble; flush_bubbles +1, stall_bubbles unchanged. Then hold=1, stall=1 -> outputs frozen for 3 cycles, no counter change.
- x0 destination: id_rd=0, id_reg_write=1, id_mem_read=1 -> ex_reg_write=0, mem_read_ID_EX=0, rd_ID_EX=0, ex_valid=1.
- Saturation: CNT_W=4, 20 consecutive stall cycles -> stall_bubbles reaches 15 and stays at 15.
